// File: rtl/serial_addsub_ctrl_if.sv
// Operand request and result return channels for the bit-serial add/subtract sequencer.
// The requester uses the master modport and the sequencer uses the slave modport.
interface serial_addsub_ctrl_if #(
    parameter int WIDTH = 4
) ();
    logic             in_valid;
    logic             in_ready;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;
    logic             busy;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, cout, ovf, busy
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, cout, ovf, busy
    );
endinterface

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract sequencer: a single full-adder cell is stepped LSB to MSB,
// one bit per clock, with a registered carry between bit positions.
//
// state | meaning
// IDLE  | waiting for an operand request; in_ready high
// RUN   | one operand bit pair through the adder cell per clock
// DONE  | result presented with out_valid; held until out_ready
module serial_addsub_ctrl #(
    parameter int WIDTH = 4
) (
    input logic               clk,
    input logic               rst,
    serial_addsub_ctrl_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] result_q;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             cout_q;
    logic             ovf_q;
    logic             sum_bit;
    logic             carry_nxt;
    logic             last;

    // The shared full-adder cell always sees the current LSBs of the shift registers.
    always_comb begin
        sum_bit   = a_sh[0] ^ b_sh[0] ^ carry;
        carry_nxt = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
        last      = (cnt == LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid) state_nxt = RUN;
            RUN:     if (last)         state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh     <= '0;
            b_sh     <= '0;
            acc      <= '0;
            result_q <= '0;
            cnt      <= '0;
            carry    <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        // Subtraction is A + ~B + 1: invert B and seed the carry with op.
                        a_sh  <= bus.a;
                        b_sh  <= bus.op ? ~bus.b : bus.b;
                        carry <= bus.op;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    acc   <= {sum_bit, acc[WIDTH-1:1]};
                    carry <= carry_nxt;
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        // carry still holds the carry into the MSB at this point.
                        result_q <= {sum_bit, acc[WIDTH-1:1]};
                        cout_q   <= carry_nxt;
                        ovf_q    <= carry ^ carry_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.result    = result_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Randomized and directed bench for serial_addsub_ctrl against an arithmetic reference model.
module tb_serial_addsub_ctrl;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [W-1:0] last_result;
    logic         last_cout;
    logic         last_ovf;

    always #5 clk = ~clk;

    serial_addsub_ctrl_if #(.WIDTH(W)) bus ();
    serial_addsub_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Plain integer arithmetic: unsigned for result/carry, signed range test for overflow.
    function automatic void model(input bit o, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] r, output logic c, output logic v);
        int          ux, uy, ur, sx, sy, sr;
        logic [31:0] tmp;
        ux = int'(x);
        uy = int'(y);
        sx = (ux >= 2**(W-1)) ? ux - 2**W : ux;
        sy = (uy >= 2**(W-1)) ? uy - 2**W : uy;
        if (!o) begin
            ur = ux + uy;
            c  = (ur >= 2**W);
            sr = sx + sy;
        end else begin
            ur = ux - uy;
            c  = (ux >= uy);
            sr = sx - sy;
        end
        tmp = ur;
        r   = tmp[W-1:0];
        v   = (sr > 2**(W-1) - 1) || (sr < -(2**(W-1)));
    endfunction

    task automatic run_op(input bit o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input int hold, input bit scramble);
        logic [W-1:0] er;
        logic         ec, ev;
        int           lat;
        bit           seen;
        model(o, x, y, er, ec, ev);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.op        = o;
        bus.a         = x;
        bus.b         = y;
        bus.out_ready = 1'($urandom_range(0, 1));
        lat = 0;
        while (!bus.in_ready && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("accept_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        lat  = 0;
        seen = 0;
        for (int i = 0; i < 3 * W && !seen; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                seen = 1;
            end else begin
                if (i == 0) begin
                    check("run_busy", 32'(bus.busy), 32'd1);
                    check("run_in_ready", 32'(bus.in_ready), 32'd0);
                end
                if (scramble) begin
                    bus.in_valid  = 1'($urandom_range(0, 1));
                    bus.op        = 1'($urandom_range(0, 1));
                    bus.a         = W'($urandom);
                    bus.b         = W'($urandom);
                    bus.out_ready = 1'($urandom_range(0, 1));
                end else begin
                    bus.in_valid = 1'b0;
                end
                @(posedge clk);
                lat++;
            end
        end
        check("out_valid_seen", 32'(seen), 32'd1);
        check("latency", 32'(lat), 32'(W));
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("result", 32'(bus.result), 32'(er));
        check("cout", 32'(bus.cout), 32'(ec));
        check("ovf", 32'(bus.ovf), 32'(ev));
        check("done_in_ready", 32'(bus.in_ready), 32'd0);
        last_result = bus.result;
        last_cout   = bus.cout;
        last_ovf    = bus.ovf;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", 32'(bus.out_valid), 32'd1);
            check("hold_result", 32'(bus.result), 32'(er));
            check("hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("release_valid", 32'(bus.out_valid), 32'd0);
        check("release_in_ready", 32'(bus.in_ready), 32'd1);
        check("release_busy", 32'(bus.busy), 32'd0);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int max_valid;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.op        = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_result", 32'(bus.result), 32'd0);
        rst = 1'b0;

        // T1: reset pulse while idle with random inputs applied
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.a         = W'($urandom);
        bus.b         = W'($urandom);
        bus.op        = 1'($urandom_range(0, 1));
        bus.out_ready = 1'($urandom_range(0, 1));
        #1 rst = 1'b1;
        @(negedge clk);
        check("t1_out_valid", 32'(bus.out_valid), 32'd0);
        check("t1_result", 32'(bus.result), 32'd0);
        check("t1_cout", 32'(bus.cout), 32'd0);
        check("t1_ovf", 32'(bus.ovf), 32'd0);
        check("t1_in_ready", 32'(bus.in_ready), 32'd1);
        check("t1_busy", 32'(bus.busy), 32'd0);
        bus.in_valid = 1'b0;
        rst          = 1'b0;

        // T2: 3+5
        run_op(1'b0, 4'd3, 4'd5, 0, 1'b0);
        check("t2_result", 32'(last_result), 32'h8);
        check("t2_cout", 32'(last_cout), 32'd0);
        check("t2_ovf", 32'(last_ovf), 32'd1);

        // T3: 7-2 and 0-1
        run_op(1'b1, 4'd7, 4'd2, 0, 1'b0);
        check("t3a_result", 32'(last_result), 32'h5);
        check("t3a_cout", 32'(last_cout), 32'd1);
        check("t3a_ovf", 32'(last_ovf), 32'd0);
        run_op(1'b1, 4'd0, 4'd1, 0, 1'b0);
        check("t3b_result", 32'(last_result), 32'hF);
        check("t3b_cout", 32'(last_cout), 32'd0);
        check("t3b_ovf", 32'(last_ovf), 32'd0);

        // T4: backpressure for 5 cycles
        run_op(1'b0, 4'd3, 4'd5, 5, 1'b0);
        check("t4_result", 32'(last_result), 32'h8);

        // T5: inputs disturbed throughout RUN
        run_op(1'b1, 4'd7, 4'd2, 2, 1'b1);
        check("t5_result", 32'(last_result), 32'h5);

        // T6: reset after two RUN edges aborts the op
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op       = 1'b1;
        bus.a        = 4'd7;
        bus.b        = 4'd2;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("t6_in_ready", 32'(bus.in_ready), 32'd1);
        check("t6_busy", 32'(bus.busy), 32'd0);
        check("t6_result", 32'(bus.result), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        max_valid = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.out_valid) max_valid = 1;
        end
        check("t6_no_valid", 32'(max_valid), 32'd0);
        run_op(1'b0, 4'd3, 4'd5, 0, 1'b0);
        check("t6_next_result", 32'(last_result), 32'h8);

        for (int k = 0; k < 40; k++) begin
            run_op(1'($urandom_range(0, 1)), W'($urandom), W'($urandom),
                   int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
